// File: rtl/cu_pkg.sv
// cu_pkg: shared encodings for the multicycle control unit.
// Holds the FSM state encoding, opcode constants, ALUOp/SrcPc/WB encodings,
// the packed control vector produced by cu_decode, and opcode-class helpers.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_e;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ANDI = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_LB   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BGT  = 4'd8;
  localparam logic [3:0] OP_BLT  = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_CALL = 4'd13;
  localparam logic [3:0] OP_RET  = 4'd14;
  localparam logic [3:0] OP_SV   = 4'd15;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RET    = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef struct packed {
    logic [1:0] src_pc;
    logic       src_rw;
    logic       src_rb;
    logic       src_ra;
    logic       reg_w;
    logic       src_a;
    logic       src_b;
    logic [1:0] alu_op;
    logic       mem_add_src;
    logic       data_in_src;
    logic       mem_w;
    logic       mem_r;
    logic [1:0] wb;
    logic       take_ext1;
    logic       take_ext2;
    logic       byte_en;
    logic       pc_we;
    logic       ir_we;
    logic       last;   // final state of the current instruction
  } cu_ctrl_t;

  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_CALL) || (op == OP_RET);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BGT) || (op == OP_BLT) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LB);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SV);
  endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational control decode for the multicycle control unit.
// Ports:
//   state  in  state_e    current FSM state
//   opcode in  4          instruction opcode
//   mode   in  1          mode bit (R0 compare / sign extension)
//   ZF, NF in  1 each     ALU flags, used for branch resolution in EXEC
//   ctrl   out cu_ctrl_t  raw control vector; the top applies handshake,
//                         enable and reset gating to the write enables
module cu_decode
  import cu_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] opcode,
  input  logic       mode,
  input  logic       ZF,
  input  logic       NF,
  output cu_ctrl_t   ctrl
);

  logic taken;

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BGT:  taken = !ZF && !NF;
      OP_BLT:  taken = NF;
      OP_BEQ:  taken = ZF;
      OP_BNE:  taken = !ZF;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_r  = 1'b1;
        ctrl.ir_we  = 1'b1;
        ctrl.pc_we  = 1'b1;
        ctrl.src_pc = PC_INC;
      end
      ST_DECODE: begin
        case (opcode)
          OP_JMP: begin
            ctrl.pc_we  = 1'b1;
            ctrl.src_pc = PC_JUMP;
            ctrl.last   = 1'b1;
          end
          OP_CALL: begin
            // link: PC written to R7 while jumping
            ctrl.pc_we  = 1'b1;
            ctrl.src_pc = PC_JUMP;
            ctrl.reg_w  = 1'b1;
            ctrl.src_rw = 1'b1;
            ctrl.wb     = WB_PC;
            ctrl.last   = 1'b1;
          end
          OP_RET: begin
            ctrl.pc_we  = 1'b1;
            ctrl.src_pc = PC_RET;
            ctrl.last   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_EXEC: begin
        if (is_branch(opcode)) begin
          ctrl.alu_op = ALU_SUB;
          ctrl.src_rb = mode;
          ctrl.last   = 1'b1;
          if (taken) begin
            ctrl.pc_we  = 1'b1;
            ctrl.src_pc = PC_BRANCH;
          end
        end
      end
      ST_MEM: begin
        if (is_load(opcode)) begin
          ctrl.mem_r       = 1'b1;
          ctrl.mem_add_src = 1'b1;
          ctrl.byte_en     = (opcode == OP_LB);
          ctrl.take_ext2   = mode;
        end else if (is_store(opcode)) begin
          ctrl.mem_w       = 1'b1;
          ctrl.mem_add_src = 1'b1;
          ctrl.data_in_src = (opcode == OP_SV);
          ctrl.last        = 1'b1;
        end
      end
      ST_WB: begin
        ctrl.reg_w = 1'b1;
        ctrl.last  = 1'b1;
        if (is_load(opcode)) begin
          ctrl.wb        = WB_MEM;
          ctrl.byte_en   = (opcode == OP_LB);
          ctrl.take_ext2 = mode;
        end else begin
          ctrl.wb = WB_ALU;
          case (opcode)
            OP_ADD, OP_ADDI: ctrl.alu_op = ALU_ADD;
            OP_SUB:          ctrl.alu_op = ALU_SUB;
            default:         ctrl.alu_op = ALU_AND;
          endcase
          if ((opcode == OP_ANDI) || (opcode == OP_ADDI)) begin
            ctrl.src_b     = 1'b1;
            ctrl.take_ext1 = 1'b1;
          end
        end
      end
      default: ;  // FAULT drives nothing
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM sequencer for a multicycle datapath.
// Owns the state register, the 8-bit memory wait/timeout counter and the
// optional performance counters; output decode lives in cu_decode.
// Ports: clk, rst_n (sync, active low), cu_enable, PC (trace only), opcode,
//   mode, ZF, NF, mem_ready in; SrcPc, SrcRW, SrcRB, SrcRA, RegW, SrcA, SrcB,
//   ALUOp, MemAddSrc, DataInSrc, MemW, MemR, WB, TakeExt1, TakeExt2, byte_en,
//   pc_we, ir_we, state, instr_done, fault out.
// Macro CU_PERF_COUNT_EN adds retired_cnt and stall_cnt outputs.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cu_enable,
  input  logic [PC_W-1:0] PC,
  input  logic [3:0]      opcode,
  input  logic            mode,
  input  logic            ZF,
  input  logic            NF,
  input  logic            mem_ready,
  output logic [1:0]      SrcPc,
  output logic            SrcRW,
  output logic            SrcRB,
  output logic            SrcRA,
  output logic            RegW,
  output logic            SrcA,
  output logic            SrcB,
  output logic [1:0]      ALUOp,
  output logic            MemAddSrc,
  output logic            DataInSrc,
  output logic            MemW,
  output logic            MemR,
  output logic [1:0]      WB,
  output logic            TakeExt1,
  output logic            TakeExt2,
  output logic            byte_en,
  output logic            pc_we,
  output logic            ir_we,
  output logic [2:0]      state,
  output logic            instr_done,
  output logic            fault
`ifdef CU_PERF_COUNT_EN
  ,
  output logic [PC_W-1:0] retired_cnt,
  output logic [PC_W-1:0] stall_cnt
`endif
);

  // Last wait count before a further idle cycle would reach MEM_TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       rst_seen_q;  // reset was sampled at the previous edge
  cu_ctrl_t   dec, vis;
  logic       mem_st, live, go, adv, waiting;
  logic       unused_pc;

  assign unused_pc = ^PC;

  cu_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .mode   (mode),
    .ZF     (ZF),
    .NF     (NF),
    .ctrl   (dec)
  );

  // The cycle after a reset edge is a dead cycle: outputs all 0, FSM holds.
  assign mem_st  = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign live    = rst_n && !rst_seen_q;
  assign go      = live && cu_enable;
  assign waiting = go && mem_st && !mem_ready;
  assign adv     = go && !(mem_st && !mem_ready);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (waiting) begin
      if (wait_q == WAIT_LAST) begin
        state_d = ST_FAULT;
        wait_d  = '0;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end else if (adv) begin
      wait_d = '0;
      case (state_q)
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: begin
          if (is_jump(opcode)) state_d = ST_FETCH;
          else                 state_d = ST_EXEC;
        end
        ST_EXEC: begin
          if (is_branch(opcode))                         state_d = ST_FETCH;
          else if (is_load(opcode) || is_store(opcode))  state_d = ST_MEM;
          else                                           state_d = ST_WB;
        end
        ST_MEM: begin
          if (is_load(opcode)) state_d = ST_WB;
          else                 state_d = ST_FETCH;
        end
        ST_WB:     state_d = ST_FETCH;
        default:   state_d = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      wait_q     <= '0;
      rst_seen_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rst_seen_q <= 1'b0;
    end
  end

  assign vis = rst_seen_q ? '0 : dec;

  assign SrcPc      = vis.src_pc;
  assign SrcRW      = vis.src_rw;
  assign SrcRB      = vis.src_rb;
  assign SrcRA      = vis.src_ra;
  assign SrcA       = vis.src_a;
  assign SrcB       = vis.src_b;
  assign ALUOp      = vis.alu_op;
  assign MemAddSrc  = vis.mem_add_src;
  assign DataInSrc  = vis.data_in_src;
  assign MemR       = vis.mem_r;
  assign WB         = vis.wb;
  assign TakeExt1   = vis.take_ext1;
  assign TakeExt2   = vis.take_ext2;
  assign byte_en    = vis.byte_en;
  // MemW stays up through the mem_ready cycle; the rest fire only on advance.
  assign MemW       = vis.mem_w & go;
  assign pc_we      = vis.pc_we & adv;
  assign ir_we      = vis.ir_we & adv;
  assign RegW       = vis.reg_w & adv;
  assign instr_done = vis.last & adv;
  assign state      = state_q;
  assign fault      = (state_q == ST_FAULT);

`ifdef CU_PERF_COUNT_EN
  logic [PC_W-1:0] retired_q, stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (instr_done) retired_q <= retired_q + PC_W'(1);
      if (waiting)    stall_q   <= stall_q + PC_W'(1);
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule
